serial_alu_n: RTL and testbench
===============================

Name: serial_alu_n

Overview:
- Parametrised, bit-serial ALU that processes one operand bit per clock, LSB first, over WIDTH bits.
- Successor to the team's fixed 4-bit serial ALU. Adds:
  - an explicit start/busy/done handshake;
  - operand latching;
  - a signed-overflow flag;
  - an absolute-difference opcode;
  - defined handling of illegal opcodes.
- Sits between the datapath operand registers and the result/flag register file.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- opcode  input  3  operation select; latched with start
- a  input  WIDTH  operand A; latched with start
- b  input  WIDTH  operand B; latched with start
- busy  output  1  high from accept until the operation completes
- done  output  1  single-cycle completion pulse
- result  output  WIDTH  result register; holds its value between operations
- carry  output  1  carry out (ADD) or borrow out (SUB/ABS_SUB)
- sign  output  1  result sign; for ABS_SUB, the true sign of B-A
- zero  output  1  result == 0
- ovf  output  1  signed overflow

Behaviour:
- Clocking and reset:
  - One clock domain: clk. Reset is synchronous and active-high (rst).
  - Reset values: result=0, carry=0, sign=0, zero=1, ovf=0, busy=0, done=0, state=IDLE, bit index=0.
  - rst during RUN or FINISH aborts the operation. No done pulse is issued and the reset values apply.
- Opcodes:
  - 000 CLR: result=0, carry=0, sign=0, zero=1, ovf=0.
  - 001 XNOR: bitwise ~(A^B).
  - 010 SUB: B-A, two's complement.
  - 011 NAND: bitwise ~(A&B).
  - 100 ADD: A+B.
  - 101 ABS_SUB: unsigned |B-A|, where A and B are signed.
  - 110, 111: illegal.
- State machine:
  - IDLE:
    - done=0.
    - If start=1: latch a, b and opcode; busy<=1; bit index<=0; internal carry<=0 (borrow<=0 for SUB/ABS_SUB).
    - Next state is RUN for opcodes 001-101, or FINISH for 000, 110 and 111.
  - RUN:
    - Each cycle computes result bit[idx] from latched A[idx], B[idx] and the internal carry/borrow.
      - ADD: {c, r} = a+b+c.
      - SUB/ABS_SUB: {bw, r} = b-a-bw.
    - idx increments each cycle. After idx=WIDTH-1 the next state is FINISH.
    - The output result/flags are not modified during RUN. The bits accumulate in a shadow register.
  - FINISH (one cycle):
    - Update result and all flags. done<=1, busy<=0, next state IDLE.
    - Illegal opcodes: result and all flags are unchanged; only done pulses.
- Latency (edge 0 = the edge that samples start):
  - Opcodes 001-101: done is high for exactly one cycle after edge WIDTH+1.
  - CLR and illegal opcodes: done is high after edge 1.
  - Back-to-back operation: start may be re-asserted in the cycle done is high. It is accepted at the next edge, because the block is in IDLE then.
- Handshake: start while busy=1 is ignored. The operation in progress and its latched operands are unaffected by input changes after accept.
- Flags computed at FINISH (r = raw WIDTH-bit result, msb = bit WIDTH-1):
  - XNOR/NAND:
    - result=r, zero=(r==0), sign=r[msb].
    - carry and ovf are cleared to 0.
  - ADD:
    - result=r, carry=final carry, zero=(r==0), sign=r[msb].
    - ovf=(a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB:
    - result=r (raw two's complement, no magnitude conversion), carry=final borrow (1 iff B<A unsigned).
    - sign=r[msb], zero=(r==0).
    - ovf=(b[msb]!=a[msb]) && (r[msb]!=b[msb]).
  - ABS_SUB:
    - neg = r[msb] ^ ovf_sub, i.e. the true signed sign of B-A.
    - result = neg ? (~r+1) mod 2^WIDTH : r. This value always fits in WIDTH bits unsigned.
    - sign=neg, carry=final borrow, ovf=0, zero=(result==0).
- Wrap-around: all arithmetic is modulo 2^WIDTH. There is no saturation.

Test Plan:
- WIDTH=4: reset, then ADD a=0111, b=0001 -> done after edge 5, result=1000, carry=0, sign=1, ovf=1, zero=0. busy is high for edges 0..4.
- WIDTH=4: SUB a=0101, b=0011 -> result=1110, carry=1, sign=1, ovf=0, zero=0. Then ABS_SUB with the same operands -> result=0010, sign=1, ovf=0.
- WIDTH=4: ABS_SUB a=1000 (-8), b=0111 (+7) -> result=1111 (15), sign=0, carry=1, ovf=0.
- WIDTH=8: XNOR a=0xA5, b=0xA5 -> result=0xFF, zero=0, sign=1, done after edge 9.
  - Then NAND a=0xFF, b=0xFF -> result=0x00, zero=1.
  - Then a start pulse during busy -> ignored; result still 0x00 at done.
- WIDTH=4: ADD a=1111, b=0001 -> result=0000, carry=1, zero=1.
  - Then opcode 110 -> done after edge 1, all outputs unchanged.
  - Then CLR -> zero=1, carry=0.
- WIDTH=8: start ADD, assert rst at edge 4 -> no done pulse, busy=0, all outputs at reset values.
  - Then a new start is accepted normally and completes with the correct result.

Source files
------------

// File: rtl/serial_alu_n.sv
// ============================================================================
// Module   : serial_alu_n
// Purpose  : WIDTH-bit bit-serial ALU, LSB first, start/busy/done handshake.
// Revision : 1.0  initial parametrised release
// ============================================================================
`default_nettype none

module serial_alu_n #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             sign,
   output logic             zero,
   output logic             ovf
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0]    c_last    = IW'(WIDTH - 1);
   localparam logic [IW-1:0]    c_idx_one = IW'(1);
   localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

   localparam logic [2:0] c_op_clr  = 3'b000;
   localparam logic [2:0] c_op_xnor = 3'b001;
   localparam logic [2:0] c_op_sub  = 3'b010;
   localparam logic [2:0] c_op_nand = 3'b011;
   localparam logic [2:0] c_op_add  = 3'b100;
   localparam logic [2:0] c_op_abs  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sh;
   logic [2:0]       r_op;
   logic [IW-1:0]    r_idx;
   logic             r_cy;

   logic             w_ai;
   logic             w_bi;
   logic             w_bit;
   logic             w_cy_nxt;
   logic             w_msb;
   logic             w_ovf_add;
   logic             w_ovf_sub;
   logic             w_neg;
   logic [WIDTH-1:0] w_mag;

   assign w_ai = r_a[r_idx];
   assign w_bi = r_b[r_idx];

   // One bit slice; r_cy holds carry for ADD and borrow for SUB/ABS_SUB.
   always_comb begin
      w_bit    = 1'b0;
      w_cy_nxt = r_cy;
      case (r_op)
         c_op_xnor: w_bit = ~(w_ai ^ w_bi);
         c_op_nand: w_bit = ~(w_ai & w_bi);
         c_op_add: begin
            w_bit    = w_ai ^ w_bi ^ r_cy;
            w_cy_nxt = (w_ai & w_bi) | ((w_ai ^ w_bi) & r_cy);
         end
         c_op_sub, c_op_abs: begin
            w_bit    = w_ai ^ w_bi ^ r_cy;
            w_cy_nxt = (~w_bi & w_ai) | (~(w_ai ^ w_bi) & r_cy);
         end
         default: ;
      endcase
   end

   assign w_msb     = r_sh[WIDTH-1];
   assign w_ovf_add = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_msb != r_a[WIDTH-1]);
   assign w_ovf_sub = (r_b[WIDTH-1] != r_a[WIDTH-1]) && (w_msb != r_b[WIDTH-1]);
   assign w_neg     = w_msb ^ w_ovf_sub;
   assign w_mag     = w_neg ? (~r_sh + c_one) : r_sh;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sh    <= '0;
         r_op    <= c_op_clr;
         r_idx   <= '0;
         r_cy    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         carry   <= 1'b0;
         sign    <= 1'b0;
         zero    <= 1'b1;
         ovf     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_op  <= opcode;
                  r_idx <= '0;
                  r_cy  <= 1'b0;
                  busy  <= 1'b1;
                  if (opcode != c_op_clr && opcode <= c_op_abs)
                     r_state <= S_RUN;
                  else
                     r_state <= S_FINISH;
               end
            end
            S_RUN: begin
               // Bits enter at the MSB end so bit 0 lands at position 0 after WIDTH shifts.
               r_sh  <= {w_bit, r_sh[WIDTH-1:1]};
               r_cy  <= w_cy_nxt;
               r_idx <= r_idx + c_idx_one;
               if (r_idx == c_last)
                  r_state <= S_FINISH;
            end
            S_FINISH: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
               case (r_op)
                  c_op_clr: begin
                     result <= '0;
                     carry  <= 1'b0;
                     sign   <= 1'b0;
                     zero   <= 1'b1;
                     ovf    <= 1'b0;
                  end
                  c_op_xnor, c_op_nand: begin
                     result <= r_sh;
                     carry  <= 1'b0;
                     sign   <= w_msb;
                     zero   <= (r_sh == '0);
                     ovf    <= 1'b0;
                  end
                  c_op_add: begin
                     result <= r_sh;
                     carry  <= r_cy;
                     sign   <= w_msb;
                     zero   <= (r_sh == '0);
                     ovf    <= w_ovf_add;
                  end
                  c_op_sub: begin
                     result <= r_sh;
                     carry  <= r_cy;
                     sign   <= w_msb;
                     zero   <= (r_sh == '0);
                     ovf    <= w_ovf_sub;
                  end
                  c_op_abs: begin
                     result <= w_mag;
                     carry  <= r_cy;
                     sign   <= w_neg;
                     zero   <= (w_mag == '0);
                     ovf    <= 1'b0;
                  end
                  default: ;
               endcase
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_n.sv
// ============================================================================
// Module   : tb_serial_alu_n
// Purpose  : Randomised and directed checks of serial_alu_n at WIDTH 4 and 8.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_alu_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       st4, st8;
   logic [2:0] op4, op8;
   logic [3:0] a4, b4, r4;
   logic [7:0] a8, b8, r8;
   logic       busy4, done4, c4, s4, z4, v4;
   logic       busy8, done8, c8, s8, z8, v8;

   serial_alu_n #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(st4), .opcode(op4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .result(r4), .carry(c4), .sign(s4),
      .zero(z4), .ovf(v4)
   );

   serial_alu_n #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(st8), .opcode(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(r8), .carry(c8), .sign(s8),
      .zero(z8), .ovf(v8)
   );

   int total = 0;
   int bad   = 0;

   int m_res[2];
   bit m_c[2], m_s[2], m_z[2], m_v[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_res[i] = 0; m_c[i] = 0; m_s[i] = 0; m_z[i] = 1; m_v[i] = 0;
      end
   endfunction

   // Reference: signed/unsigned integer arithmetic on whole operands.
   function automatic void model(input int s, input int op, input int a, input int b);
      int w, mask, half, sa, sb, t, r;
      w    = s ? 8 : 4;
      mask = (1 << w) - 1;
      half = 1 << (w - 1);
      sa   = (a >= half) ? a - (1 << w) : a;
      sb   = (b >= half) ? b - (1 << w) : b;
      case (op)
         0: begin m_res[s] = 0; m_c[s] = 0; m_s[s] = 0; m_z[s] = 1; m_v[s] = 0; end
         1, 3: begin
            r = (op == 1) ? (~(a ^ b)) & mask : (~(a & b)) & mask;
            m_res[s] = r; m_c[s] = 0; m_v[s] = 0; m_s[s] = (r >= half); m_z[s] = (r == 0);
         end
         4: begin
            r = (a + b) & mask; t = sa + sb;
            m_res[s] = r; m_c[s] = (a + b) > mask; m_s[s] = (r >= half); m_z[s] = (r == 0);
            m_v[s] = (t > half - 1) || (t < -half);
         end
         2: begin
            r = (b - a) & mask; t = sb - sa;
            m_res[s] = r; m_c[s] = (b < a); m_s[s] = (r >= half); m_z[s] = (r == 0);
            m_v[s] = (t > half - 1) || (t < -half);
         end
         5: begin
            t = sb - sa;
            r = (t < 0) ? -t : t;
            m_res[s] = r; m_c[s] = (b < a); m_s[s] = (t < 0); m_z[s] = (r == 0); m_v[s] = 0;
         end
         default: ;
      endcase
   endfunction

   task automatic drive(input int s, input logic st, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b);
      if (s != 0) begin st8 = st; op8 = op; a8 = a; b8 = b; end
      else begin st4 = st; op4 = op; a4 = a[3:0]; b4 = b[3:0]; end
   endtask

   task automatic sample(input int s, output logic [7:0] r, output logic bsy, output logic dn,
                         output logic c, output logic sg, output logic z, output logic v);
      if (s != 0) begin r = r8; bsy = busy8; dn = done8; c = c8; sg = s8; z = z8; v = v8; end
      else begin r = {4'b0, r4}; bsy = busy4; dn = done4; c = c4; sg = s4; z = z4; v = v4; end
   endtask

   task automatic check_outputs(input int s);
      logic [7:0] r;
      logic bsy, dn, c, sg, z, v;
      sample(s, r, bsy, dn, c, sg, z, v);
      chk("result", {24'b0, r}, m_res[s]);
      chk("carry", {31'b0, c}, {31'b0, m_c[s]});
      chk("sign", {31'b0, sg}, {31'b0, m_s[s]});
      chk("zero", {31'b0, z}, {31'b0, m_z[s]});
      chk("ovf", {31'b0, v}, {31'b0, m_v[s]});
   endtask

   task automatic do_op(input int s, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input bit glitch);
      int w, lat, n, ai, bi;
      bit seen;
      logic [7:0] r;
      logic bsy, dn, c, sg, z, v;
      w   = (s != 0) ? 8 : 4;
      ai  = (s != 0) ? int'(a) : int'(a[3:0]);
      bi  = (s != 0) ? int'(b) : int'(b[3:0]);
      lat = (op >= 3'd1 && op <= 3'd5) ? w + 1 : 1;
      @(negedge clk);
      drive(s, 1'b1, op, a, b);
      @(posedge clk); #1;
      drive(s, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom));
      sample(s, r, bsy, dn, c, sg, z, v);
      chk("busy_on", {31'b0, bsy}, 32'd1);
      chk("done_low", {31'b0, dn}, 32'd0);
      seen = 0;
      n    = 0;
      for (int k = 1; k <= w + 8; k++) begin
         if (glitch && k == 2) drive(s, 1'b1, 3'($urandom), 8'($urandom), 8'($urandom));
         @(posedge clk); #1;
         if (glitch && k == 2) drive(s, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom));
         sample(s, r, bsy, dn, c, sg, z, v);
         if (dn) begin seen = 1; n = k; break; end
      end
      if (!seen) chk("timeout", 32'd0, 32'd1);
      else begin
         chk("latency", n, lat);
         chk("busy_off", {31'b0, bsy}, 32'd0);
         model(s, int'(op), ai, bi);
         check_outputs(s);
      end
   endtask

   initial begin
      logic [7:0] r;
      logic bsy, dn, c, sg, z, v;
      bit any_done;
      rst = 1'b1;
      drive(0, 1'b0, 3'd0, 8'd0, 8'd0);
      drive(1, 1'b0, 3'd0, 8'd0, 8'd0);
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sample(s, r, bsy, dn, c, sg, z, v);
         chk("rst_busy", {31'b0, bsy}, 32'd0);
         chk("rst_done", {31'b0, dn}, 32'd0);
         check_outputs(s);
      end

      do_op(0, 3'b100, 8'h07, 8'h01, 0);
      do_op(0, 3'b010, 8'h05, 8'h03, 0);
      do_op(0, 3'b101, 8'h05, 8'h03, 0);
      do_op(0, 3'b101, 8'h08, 8'h07, 0);
      do_op(1, 3'b001, 8'hA5, 8'hA5, 0);
      do_op(1, 3'b011, 8'hFF, 8'hFF, 0);
      do_op(1, 3'b100, 8'h3C, 8'h11, 1);
      do_op(0, 3'b100, 8'h0F, 8'h01, 0);
      do_op(0, 3'b110, 8'h03, 8'h09, 0);
      do_op(0, 3'b111, 8'h0A, 8'h02, 0);
      do_op(0, 3'b000, 8'h0C, 8'h0D, 0);

      // Abort an ADD mid-run with reset at edge 4.
      @(negedge clk);
      drive(1, 1'b1, 3'b100, 8'h12, 8'h34);
      @(posedge clk); #1;
      drive(1, 1'b0, 3'b000, 8'h00, 8'h00);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      sample(1, r, bsy, dn, c, sg, z, v);
      chk("abort_busy", {31'b0, bsy}, 32'd0);
      chk("abort_done", {31'b0, dn}, 32'd0);
      check_outputs(1);
      check_outputs(0);
      any_done = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (done8 !== 1'b0) any_done = 1;
      end
      chk("abort_no_done", {31'b0, any_done}, 32'd0);
      do_op(1, 3'b100, 8'h7F, 8'h01, 0);

      for (int i = 0; i < 60; i++) begin
         int s;
         logic [2:0] op;
         s  = i % 2;
         op = 3'($urandom_range(0, 7));
         do_op(s, op, 8'($urandom), 8'($urandom),
               (op >= 3'd1 && op <= 3'd5) ? bit'($urandom_range(0, 1)) : 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
